// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S serial audio receiver with valid/ready stereo frame output
//
// Purpose: oversamples an asynchronous I2S stream (bclk/lrck/sdin) in the clk
// domain, deserialises left and right slots MSB-first and presents one stereo
// frame per lrck period.
// Optional build macro: I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB coincident with the lrck change, lrck=1 is left).
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx_en               receiver enable; low drops any partial frame
//   i2s_bclk/lrck/sdin  asynchronous I2S inputs
//   audio_l, audio_r    captured samples, two's complement, left-aligned
//   sample_valid/ready  frame handshake
//   overrun             1-clk pulse: an unconsumed frame was overwritten
//   frame_err           1-clk pulse: a slot ended with fewer than DATA_WIDTH bits
module i2s_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrck,
    input  logic                  i2s_sdin,
    output logic [DATA_WIDTH-1:0] audio_l,
    output logic [DATA_WIDTH-1:0] audio_r,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    output logic                  frame_err
);

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LEFT_LVL = 1'b1;
    localparam logic NO_DELAY = 1'b1;
`else
    localparam logic LEFT_LVL = 1'b0;
    localparam logic NO_DELAY = 1'b0;
`endif

    localparam logic [5:0]            DW      = 6'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdin_sync;
    logic                   bclk_hist;
    logic                   bclk_rise;

    // Sample stage: lrck/sdin captured on bclk_rise, acted on one clk later.
    logic tick, smp_lrck, smp_sdin;
    logic lrck_prev, have_prev;

    logic [DATA_WIDTH-1:0] shreg, left_hold, word_cur;
    logic [5:0]            cnt, cnt_cur;

    logic bnd, start_bnd, mid_bnd;
    logic commit, store_left;
    logic bit_to_cur, room, short_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            sdin_sync <= '0;
            bclk_hist <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], i2s_sdin};
            bclk_hist <= bclk_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick      <= 1'b0;
            smp_lrck  <= 1'b0;
            smp_sdin  <= 1'b0;
            lrck_prev <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            tick <= bclk_rise;
            if (bclk_rise) begin
                smp_lrck <= lrck_sync[SYNC_STAGES-1];
                smp_sdin <= sdin_sync[SYNC_STAGES-1];
            end
            if (tick) begin
                lrck_prev <= smp_lrck;
            end
            // The first sample after enabling only seeds lrck_prev, so a stale
            // level from before the enable can never fake a boundary.
            have_prev <= (state != IDLE) & (have_prev | tick);
        end
    end

    assign bnd       = tick & have_prev & (smp_lrck ^ lrck_prev);
    assign start_bnd = bnd & (smp_lrck == LEFT_LVL);
    assign mid_bnd   = bnd & (smp_lrck != LEFT_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        store_left = 1'b0;
        case (state)
            IDLE:  if (rx_en) state_next = SYNC;
            SYNC:  if (start_bnd) state_next = LEFT;
            LEFT:  if (mid_bnd) begin
                       state_next = RIGHT;
                       store_left = rx_en;
                   end
            RIGHT: if (start_bnd) begin
                       state_next = LEFT;
                       commit     = rx_en;
                   end
            default: state_next = IDLE;
        endcase
        if (!rx_en) begin
            state_next = IDLE;
        end
    end

    // In I2S mode the bit sampled at a boundary is the LSB of the slot that is
    // ending; in left-justified mode it is the MSB of the slot that starts.
    assign bit_to_cur = tick & ~(bnd & NO_DELAY);
    assign room       = cnt < DW;
    assign word_cur   = shreg | ((bit_to_cur & room & smp_sdin) ? (MSB_ONE >> cnt) : '0);
    assign cnt_cur    = (bit_to_cur & room) ? cnt + 6'd1 : cnt;
    assign short_slot = cnt_cur < DW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            cnt          <= '0;
            left_hold    <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || !rx_en) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (bnd) begin
                if (NO_DELAY) begin
                    shreg <= smp_sdin ? MSB_ONE : '0;
                    cnt   <= 6'd1;
                end else begin
                    shreg <= '0;
                    cnt   <= '0;
                end
            end else if (tick) begin
                shreg <= word_cur;
                cnt   <= cnt_cur;
            end

            if (store_left) begin
                left_hold <= word_cur;
                frame_err <= short_slot;
            end

            if (!rx_en) begin
                sample_valid <= 1'b0;
            end else if (commit) begin
                audio_l      <= left_hold;
                audio_r      <= word_cur;
                sample_valid <= 1'b1;
                overrun      <= sample_valid & ~sample_ready;
                frame_err    <= short_slot;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed self-checking bench for i2s_rx
module tb_i2s_rx;
    localparam int SS   = 2;
    localparam int HALF = 16;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LV = 1'b1;
    localparam logic LJ = 1'b1;
`else
    localparam logic LV = 1'b0;
    localparam logic LJ = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, rx_en = 1'b0;
    logic        i2s_bclk = 1'b1, i2s_lrck = 1'b0, i2s_sdin = 1'b0, sample_ready = 1'b1;
    logic [31:0] audio_l, audio_r;
    logic        sample_valid, overrun, frame_err;

    int total = 0, bad = 0;
    int cyc = 0, rise_cyc = 0, vrise_cyc = 0, vcyc = 0, xfers = 0, ovrs = 0, ferrs = 0;
    logic [31:0] xl = '0, xr = '0;
    logic        vq = 1'b0;

    i2s_rx #(.DATA_WIDTH(32), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdin(i2s_sdin),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_valid && !vq) vrise_cyc = cyc;
        vq = sample_valid;
        if (sample_valid) vcyc++;
        if (sample_valid && sample_ready) begin xfers++; xl = audio_l; xr = audio_r; end
        if (overrun) ovrs++;
        if (frame_err) ferrs++;
    end

    task automatic bit_out(input logic l, input logic d);
        @(posedge clk); #2;
        i2s_bclk = 1'b0; i2s_lrck = l; i2s_sdin = d;
        repeat (HALF) @(posedge clk);
        #2; i2s_bclk = 1'b1; rise_cyc = cyc;
        repeat (HALF - 1) @(posedge clk);
    endtask

    // Sends bit positions k0..k1 (0 = MSB) of an n-bit slot.
    task automatic send_bits(input logic is_left, input logic [31:0] w, input int n, input int k0, input int k1);
        logic lv;
        lv = is_left ? LV : ~LV;
        for (int k = k0; k <= k1; k++) bit_out((LJ || k != n - 1) ? lv : ~lv, w[n-1-k]);
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_bits(1'b1, l, n, 0, n - 1);
        send_bits(1'b0, r, n, 0, n - 1);
    endtask

    task automatic end_frame();
        if (LJ) bit_out(LV, 1'b0);
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic start();
        @(posedge clk); #2;
        rst = 1'b1; rx_en = 1'b0; sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2; rst = 1'b0; rx_en = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        total++; if (audio_l !== 32'h0) begin bad++; $display("FAIL rst_audio_l got=%h exp=0", audio_l); end
        total++; if (audio_r !== 32'h0) begin bad++; $display("FAIL rst_audio_r got=%h exp=0", audio_r); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_single_frame();
        int x0, v0, o0, f0;
        start();
        send_bits(1'b0, 32'hDEADBEEF, 32, 0, 31);
        x0 = xfers; v0 = vcyc; o0 = ovrs; f0 = ferrs;
        frame(32'h12345678, 32'h9ABCDEF0, 32);
        end_frame();
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL single_xfers got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'h12345678) begin bad++; $display("FAIL single_l got=%h exp=12345678", xl); end
        total++; if (xr !== 32'h9ABCDEF0) begin bad++; $display("FAIL single_r got=%h exp=9abcdef0", xr); end
        total++; if (vcyc - v0 !== 1) begin bad++; $display("FAIL single_valid_width got=%0d exp=1", vcyc - v0); end
        total++; if (vrise_cyc - rise_cyc !== SS + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", vrise_cyc - rise_cyc, SS + 2); end
        total++; if (ovrs - o0 !== 0) begin bad++; $display("FAIL single_overrun got=%0d exp=0", ovrs - o0); end
        total++; if (ferrs - f0 !== 0) begin bad++; $display("FAIL single_frame_err got=%0d exp=0", ferrs - f0); end
    endtask

    task automatic test_extreme_values();
        int f0;
        start();
        send_bits(1'b0, 32'h0, 32, 0, 31);
        f0 = ferrs;
        frame(32'h80000001, 32'h7FFFFFFF, 32);
        end_frame();
        total++; if (xl !== 32'h80000001) begin bad++; $display("FAIL extreme_l got=%h exp=80000001", xl); end
        total++; if (xr !== 32'h7FFFFFFF) begin bad++; $display("FAIL extreme_r got=%h exp=7fffffff", xr); end
        total++; if (ferrs - f0 !== 0) begin bad++; $display("FAIL extreme_frame_err got=%0d exp=0", ferrs - f0); end
    endtask

    task automatic test_mid_frame();
        int x0;
        @(posedge clk); #2;
        rst = 1'b1; rx_en = 1'b0; sample_ready = 1'b1;
        x0 = xfers;
        send_bits(1'b0, 32'h0F0F0F0F, 32, 0, 7);
        @(posedge clk); #2;
        rst = 1'b0; rx_en = 1'b1;
        send_bits(1'b0, 32'h0F0F0F0F, 32, 8, 31);
        frame(32'hCAFEF00D, 32'h0BADBEEF, 32);
        end_frame();
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL mid_xfers got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_l got=%h exp=cafef00d", xl); end
        total++; if (xr !== 32'h0BADBEEF) begin bad++; $display("FAIL mid_r got=%h exp=0badbeef", xr); end
    endtask

    task automatic test_backpressure();
        int x0, o0;
        start();
        send_bits(1'b0, 32'h0, 32, 0, 31);
        sample_ready = 1'b0;
        x0 = xfers; o0 = ovrs;
        frame(32'h1, 32'h2, 32);
        frame(32'h3, 32'h4, 32);
        end_frame();
        total++; if (ovrs - o0 !== 1) begin bad++; $display("FAIL bp_overrun got=%0d exp=1", ovrs - o0); end
        total++; if (audio_l !== 32'h3) begin bad++; $display("FAIL bp_audio_l got=%h exp=3", audio_l); end
        total++; if (audio_r !== 32'h4) begin bad++; $display("FAIL bp_audio_r got=%h exp=4", audio_r); end
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held got=%b exp=1", sample_valid); end
        total++; if (xfers - x0 !== 0) begin bad++; $display("FAIL bp_no_xfer got=%0d exp=0", xfers - x0); end
        sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL bp_xfer got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'h3) begin bad++; $display("FAIL bp_xfer_l got=%h exp=3", xl); end
        total++; if (xr !== 32'h4) begin bad++; $display("FAIL bp_xfer_r got=%h exp=4", xr); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", sample_valid); end
    endtask

    task automatic test_short_slot();
        int f0, x0;
        start();
        send_bits(1'b0, 32'h0, 24, 0, 23);
        f0 = ferrs; x0 = xfers;
        frame(32'h00ABCDEF, 32'h00123456, 24);
        end_frame();
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL short_xfers got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'hABCDEF00) begin bad++; $display("FAIL short_l got=%h exp=abcdef00", xl); end
        total++; if (xr !== 32'h12345600) begin bad++; $display("FAIL short_r got=%h exp=12345600", xr); end
        total++; if (ferrs - f0 !== 2) begin bad++; $display("FAIL short_frame_err got=%0d exp=2", ferrs - f0); end
    endtask

    task automatic test_reset_mid();
        int x0;
        start();
        send_bits(1'b0, 32'h0, 32, 0, 31);
        frame(32'h11112222, 32'h33334444, 32);
        end_frame();
        total++; if (audio_l !== 32'h11112222) begin bad++; $display("FAIL rmid_pre_l got=%h exp=11112222", audio_l); end
        send_bits(1'b1, 32'h5A5A5A5A, 32, 0, 9);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (audio_l !== 32'h0) begin bad++; $display("FAIL rmid_async_l got=%h exp=0", audio_l); end
        total++; if (audio_r !== 32'h0) begin bad++; $display("FAIL rmid_async_r got=%h exp=0", audio_r); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rmid_async_valid got=%b exp=0", sample_valid); end
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        x0 = xfers;
        send_bits(1'b1, 32'h5A5A5A5A, 32, 10, 31);
        send_bits(1'b0, 32'hFFFFFFFF, 32, 0, 31);
        end_frame();
        total++; if (xfers - x0 !== 0) begin bad++; $display("FAIL rmid_partial_xfer got=%0d exp=0", xfers - x0); end
        total++; if (audio_l !== 32'h0) begin bad++; $display("FAIL rmid_partial_l got=%h exp=0", audio_l); end
        frame(32'h76543210, 32'hFEDCBA98, 32);
        end_frame();
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL rmid_fresh_xfer got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'h76543210) begin bad++; $display("FAIL rmid_fresh_l got=%h exp=76543210", xl); end
        total++; if (xr !== 32'hFEDCBA98) begin bad++; $display("FAIL rmid_fresh_r got=%h exp=fedcba98", xr); end
    endtask

    task automatic test_disable();
        int x0;
        start();
        sample_ready = 1'b0;
        send_bits(1'b0, 32'h0, 32, 0, 31);
        frame(32'h55AA55AA, 32'hA55AA55A, 32);
        end_frame();
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL dis_pre_valid got=%b exp=1", sample_valid); end
        send_bits(1'b1, 32'h13572468, 32, 0, 7);
        @(posedge clk); #2;
        rx_en = 1'b0;
        @(posedge clk); #2;
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL dis_valid got=%b exp=0", sample_valid); end
        total++; if (audio_l !== 32'h55AA55AA) begin bad++; $display("FAIL dis_hold_l got=%h exp=55aa55aa", audio_l); end
        total++; if (audio_r !== 32'hA55AA55A) begin bad++; $display("FAIL dis_hold_r got=%h exp=a55aa55a", audio_r); end
        rx_en = 1'b1; sample_ready = 1'b1;
        x0 = xfers;
        send_bits(1'b1, 32'h13572468, 32, 8, 31);
        send_bits(1'b0, 32'h0, 32, 0, 31);
        frame(32'h24681357, 32'h0F1E2D3C, 32);
        end_frame();
        total++; if (xfers - x0 !== 1) begin bad++; $display("FAIL dis_reen_xfer got=%0d exp=1", xfers - x0); end
        total++; if (xl !== 32'h24681357) begin bad++; $display("FAIL dis_reen_l got=%h exp=24681357", xl); end
        total++; if (xr !== 32'h0F1E2D3C) begin bad++; $display("FAIL dis_reen_r got=%h exp=0f1e2d3c", xr); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_extreme_values();
        test_mid_frame();
        test_backpressure();
        test_short_slot();
        test_reset_mid();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Serial audio input stage. Directly upstream of comb_filter.
- Oversamples an external I2S stream (BCLK/LRCK/SDIN) in the system clock domain.
- Deserialises left and right slots and presents one stereo frame per LRCK period on a valid/ready interface.
- comb_filter consumes audio_l/audio_r as its 32-bit audio_in.

Parameters:
- DATA_WIDTH, 32: bits kept per channel, MSB-first; range 8..32.
- SYNC_STAGES, 2: synchroniser flops on each I2S input; range 2..3.

Ports:
- clk  in  1  system clock; must be ≥ 8× BCLK.
- rst  in  1  asynchronous, active-high reset.
- rx_en  in  1  receiver enable.
- i2s_bclk  in  1  external bit clock, asynchronous.
- i2s_lrck  in  1  word select (0 = left, 1 = right), asynchronous.
- i2s_sdin  in  1  serial data, asynchronous.
- audio_l  out  DATA_WIDTH  left sample, two's complement.
- audio_r  out  DATA_WIDTH  right sample, two's complement.
- sample_valid  out  1  frame available.
- sample_ready  in  1  consumer accepts frame.
- overrun  out  1  1-clk pulse: unconsumed frame overwritten.
- frame_err  out  1  1-clk pulse: slot shorter than DATA_WIDTH.

Behaviour:
- **Reset** (async, rst=1): all outputs 0; state IDLE; counters, shift registers and synchronisers cleared. Asserting rst mid-frame discards the partial frame; no valid or pulse is generated.
- **Input conditioning**
  - Each I2S input passes through SYNC_STAGES flops, then one history flop.
  - bclk_rise = sync_bclk & ~hist_bclk, one clk wide.
  - All sampling happens on clk cycles where bclk_rise=1. lrck and sdin are sampled together, using synchronised values.
- **Framing** (Philips I2S, 1-BCLK delay)
  - A word boundary is a bclk_rise where the sampled lrck differs from the lrck sampled at the previous bclk_rise.
  - The MSB of the new slot is the sdin sampled at the next bclk_rise.
- **FSM states:** IDLE, SYNC, LEFT, RIGHT.
  - IDLE: wait for rx_en=1, then go to SYNC.
  - SYNC: wait for a 1→0 lrck boundary, then go to LEFT. Frames are never emitted before the first left start.
  - LEFT: on a 0→1 boundary, go to RIGHT and store the left slot.
  - RIGHT: on a 1→0 boundary, commit the frame and go to LEFT.
  - rx_en=0 in any state: go to IDLE next clk. Any partial frame is dropped, sample_valid clears, audio_l/audio_r hold their values.
- **Slot capture**
  - A 6-bit bit counter resets at each boundary.
  - The first DATA_WIDTH bits shift in MSB-first. Bits beyond DATA_WIDTH are ignored; the counter saturates.
  - A slot that ends with fewer than DATA_WIDTH bits is left-aligned with LSBs zero-filled, and frame_err pulses at that boundary.
- **Commit and latency**
  - On the clk after the commit bclk_rise, audio_l/audio_r load and sample_valid=1.
  - End-to-end: the external BCLK edge reaches sample_valid in SYNC_STAGES+2 clk.
- **Handshake**
  - The frame transfers when sample_valid & sample_ready on a rising clk edge; sample_valid drops next cycle unless a commit occurs in that same cycle.
  - Commit while sample_valid=1 & sample_ready=0: the new frame overwrites, sample_valid stays 1, overrun pulses.
  - Commit in the same cycle as a transfer: the new frame loads, sample_valid stays 1, no overrun.
  - sample_ready is ignored while sample_valid=0.
- **Glitch tolerance:** the bclk high and low phases must each last ≥ 3 clk. Shorter phases give undefined data, but the FSM must not lock up; the next valid 1→0 boundary resynchronises it.

Optional Feature:
- Macro: I2S_RX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. The MSB is the sdin sampled at the same bclk_rise as the lrck change (no 1-BCLK delay); that bit counts as bit 0 of the new slot. lrck=1 is left, so SYNC waits for a 0→1 boundary and commit occurs on a 0→1 boundary.
- Undefined: standard I2S as described under Behaviour.
- Ports and handshake are identical in both builds.

Test Plan:
- Common setup: clk 100 MHz, BCLK 3.125 MHz (32 clk/bit), 32-bit slots, rx_en=1, sample_ready=1.
- Single frame: send L=0x12345678, R=0x9ABCDEF0 → audio_l=0x12345678 and audio_r=0x9ABCDEF0 with one 1-clk sample_valid, arriving SYNC_STAGES+2 clk after the BCLK edge sampling the lrck 1→0 boundary; overrun=0; frame_err=0.
- Start mid-frame: release rst while lrck=1 in the middle of a right slot → no valid until a full L/R pair; first frame equals the first complete pair sent.
- Backpressure: sample_ready=0, send frames A=(0x1,0x2) then B=(0x3,0x4) → after B, overrun pulses once and audio_l/audio_r=0x3/0x4; raise sample_ready → one transfer, then sample_valid=0.
- Short slot: 24-bit slots carrying L=0xABCDEF, R=0x123456 → audio_l=0xABCDEF00, audio_r=0x12345600, frame_err pulses twice per frame.
- Reset/disable mid-frame: assert rst during bit 10 of a left slot, then release → outputs 0 and no valid until a fresh full frame. rx_en=0 mid-frame → sample_valid=0 next clk and audio_l/audio_r unchanged.
- With I2S_RX_LEFT_JUSTIFIED_EN: L=0x80000001, R=0x7FFFFFFF with no 1-BCLK delay → same values captured and no frame_err.
